// File: rtl/convolution_procesor_core.sv
// Convolution sequencer: walks every output index i of Z = X * Y, reads X/Y
// sample pairs from synchronous RAMs, multiply-accumulates the in-range pairs
// and writes each finished Z sample before pulsing done.
module convolution_procesor_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] size_x,
    input  logic [ADDR_WIDTH-1:0] size_y,
    output logic [ADDR_WIDTH-1:0] mem_x_addr,
    input  logic [DATA_WIDTH-1:0] mem_x_data,
    output logic [ADDR_WIDTH-1:0] mem_y_addr,
    input  logic [DATA_WIDTH-1:0] mem_y_data,
    output logic [ADDR_WIDTH:0]   mem_z_addr,
    output logic [ACC_WIDTH-1:0]  mem_z_data,
    output logic                  mem_z_we,
    output logic                  busy,
    output logic                  done
);

    // One extra bit on indices and sizes so i-k and the bound checks never wrap.
    localparam int IW = ADDR_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_READ, S_ACC, S_WRITE, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   sx, sy, i, k;
    logic [IW-1:0]   diff, last_i, last_k;
    logic            valid;
    logic [ACC_WIDTH-1:0] acc;
    logic [PW-1:0]   prod;
    logic            size_zero;

    assign diff      = i - k;
    assign last_i    = sx + sy - IW'(2);
    assign last_k    = sy - IW'(1);
    assign prod      = PW'(mem_x_data) * PW'(mem_y_data);
    assign size_zero = (size_x == '0) || (size_y == '0);

    // State register; async reset returns straight to IDLE.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and memory/handshake outputs, all decoded from current state.
    always_comb begin
        state_nxt  = state;
        mem_x_addr = '0;
        mem_y_addr = '0;
        mem_z_addr = '0;
        mem_z_data = '0;
        mem_z_we   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = size_zero ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                state_nxt = S_READ;
            end
            S_READ: begin
                busy       = 1'b1;
                mem_x_addr = diff[ADDR_WIDTH-1:0];
                mem_y_addr = k[ADDR_WIDTH-1:0];
                state_nxt  = S_ACC;
            end
            S_ACC: begin
                // Addresses held so the RAM outputs stay tied to this pair.
                busy       = 1'b1;
                mem_x_addr = diff[ADDR_WIDTH-1:0];
                mem_y_addr = k[ADDR_WIDTH-1:0];
                state_nxt  = (k == last_k) ? S_WRITE : S_READ;
            end
            S_WRITE: begin
                busy       = 1'b1;
                mem_z_we   = 1'b1;
                mem_z_addr = i;
                mem_z_data = acc;
                state_nxt  = (i == last_i) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: size latch, index counters, in-range flag and accumulator.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            sx    <= '0;
            sy    <= '0;
            i     <= '0;
            k     <= '0;
            acc   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sx <= {1'b0, size_x};
                        sy <= {1'b0, size_y};
                        i  <= '0;
                    end
                end
                S_CLEAR: begin
                    acc <= '0;
                    k   <= '0;
                end
                S_READ: begin
                    valid <= (i >= k) && (diff < sx);
                end
                S_ACC: begin
                    // Out-of-range pairs still spend their cycles; only the add is skipped.
                    if (valid) acc <= acc + ACC_WIDTH'(prod);
                    if (k != last_k) k <= k + IW'(1);
                end
                S_WRITE: begin
                    if (i != last_i) i <= i + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_convolution_procesor_core.sv
// Bench for convolution_procesor_core: synchronous X/Y RAM models, a plain
// convolution/timing model, a per-cycle compare task and literal spot checks.
module tb_convolution_procesor_core;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        start;
    logic [4:0]  size_x, size_y;
    logic [4:0]  mem_x_addr, mem_y_addr;
    logic [7:0]  mem_x_data, mem_y_data;
    logic [5:0]  mem_z_addr;
    logic [20:0] mem_z_data;
    logic        mem_z_we, busy, done;

    logic [7:0]  xmem [0:31];
    logic [7:0]  ymem [0:31];
    longint      zexp [0:63];
    longint      zmem [0:63];
    int          wcnt, cyc, T, per, n_tests, n_fail;
    bit          mon_on;

    convolution_procesor_core dut (
        .clk(clk), .rst_a(rst_a), .start(start),
        .size_x(size_x), .size_y(size_y),
        .mem_x_addr(mem_x_addr), .mem_x_data(mem_x_data),
        .mem_y_addr(mem_y_addr), .mem_y_data(mem_y_data),
        .mem_z_addr(mem_z_addr), .mem_z_data(mem_z_data), .mem_z_we(mem_z_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample memories, one cycle of latency.
    always @(posedge clk) begin
        mem_x_data <= xmem[mem_x_addr];
        mem_y_data <= ymem[mem_y_addr];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected Z by direct convolution, and expected run length in cycles.
    task automatic model(input int sx, input int sy);
        per = 2*sy + 2;
        T   = (sx == 0 || sy == 0) ? 1 : (sx + sy - 1) * per + 1;
        for (int n = 0; n < 64; n++) zexp[n] = 0;
        if (sx != 0 && sy != 0)
            for (int n = 0; n < sx + sy - 1; n++)
                for (int kk = 0; kk < sy; kk++)
                    if (n - kk >= 0 && n - kk < sx)
                        zexp[n] += longint'(xmem[n-kk]) * longint'(ymem[kk]);
    endtask

    task automatic fill_garbage();
        for (int a = 0; a < 32; a++) begin
            xmem[a] = 8'hA5;
            ymem[a] = 8'h5A;
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        int idx;
        @(negedge clk);
        if (mon_on) begin
            cyc++;
            chk("busy", longint'(busy), longint'(cyc < T));
            chk("done", longint'(done), longint'(cyc == T));
            chk("z_we", longint'(mem_z_we), longint'((cyc < T) && (cyc % per == 0)));
            if (mem_z_we) begin
                idx = cyc / per - 1;
                if (idx < 0) idx = 0;
                chk("z_addr", longint'(mem_z_addr), longint'(idx));
                chk("z_data", longint'(mem_z_data), zexp[idx]);
            end
            if (cyc >= T) mon_on = 1'b0;
        end else begin
            chk("idle_busy", longint'(busy), 0);
            chk("idle_done", longint'(done), 0);
            chk("idle_we", longint'(mem_z_we), 0);
        end
        if (mem_z_we) begin
            zmem[mem_z_addr] = longint'(mem_z_data);
            wcnt++;
        end
    endtask

    task automatic launch(input int sx, input int sy);
        model(sx, sy);
        size_x = 5'(sx);
        size_y = 5'(sy);
        start  = 1'b1;
        mon_on = 1'b1;
        cyc    = 0;
    endtask

    // One full operation; 'extra' adds stray starts and size changes mid-run.
    task automatic run(input int sx, input int sy, input bit extra);
        int w0;
        w0 = wcnt;
        launch(sx, sy);
        for (int j = 1; j <= T + 2; j++) begin
            tick();
            start = extra && (j == 3 || j == 4 || j == T);
            if (extra && j == 3) begin
                size_x = 5'd7;
                size_y = 5'd9;
            end
        end
        start = 1'b0;
        chk("write_count", longint'(wcnt - w0),
            (sx == 0 || sy == 0) ? 0 : longint'(sx + sy - 1));
    endtask

    task automatic load_case1();
        fill_garbage();
        xmem[0] = 8'd1; xmem[1] = 8'd2; xmem[2] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd1;
    endtask

    task automatic check_case1(input string tag);
        chk({tag, "_z0"}, zmem[0], 1);
        chk({tag, "_z1"}, zmem[1], 3);
        chk({tag, "_z2"}, zmem[2], 5);
        chk({tag, "_z3"}, zmem[3], 3);
    endtask

    initial begin
        int w0;
        n_tests = 0; n_fail = 0; wcnt = 0; cyc = 0; mon_on = 1'b0;
        T = 1; per = 2;
        rst_a = 1'b0; start = 1'b0; size_x = '0; size_y = '0;
        fill_garbage();
        for (int n = 0; n < 64; n++) zmem[n] = -1;

        repeat (2) tick();
        chk("rst_x_addr", longint'(mem_x_addr), 0);
        chk("rst_y_addr", longint'(mem_y_addr), 0);
        chk("rst_z_addr", longint'(mem_z_addr), 0);
        chk("rst_z_data", longint'(mem_z_data), 0);
        rst_a = 1'b1;
        repeat (2) tick();

        // X={1,2,3}, Y={1,1}
        load_case1();
        run(3, 2, 1'b0);
        chk("case1_T", T, 25);
        check_case1("case1");

        // Single-sample operands
        fill_garbage();
        xmem[0] = 8'd5; ymem[0] = 8'd7;
        run(1, 1, 1'b0);
        chk("single_T", T, 5);
        chk("single_z0", zmem[0], 35);

        // Y longer than X
        fill_garbage();
        xmem[0] = 8'd2; xmem[1] = 8'd3;
        ymem[0] = 8'd1; ymem[1] = 8'd2; ymem[2] = 8'd3; ymem[3] = 8'd4;
        run(2, 4, 1'b0);
        chk("short_x_z1", zmem[1], 7);
        chk("short_x_z4", zmem[4], 12);

        // Maximum sizes, all samples 255
        for (int a = 0; a < 32; a++) begin
            xmem[a] = 8'hFF;
            ymem[a] = 8'hFF;
        end
        run(31, 31, 1'b0);
        chk("max_z0", zmem[0], 65025);
        chk("max_z30", zmem[30], 2015775);
        chk("max_z60", zmem[60], 65025);

        // Zero size: done the cycle after start, no writes
        run(0, 4, 1'b0);
        chk("zero_T", T, 1);

        // Repeated starts while busy, including one on the done cycle
        load_case1();
        for (int n = 0; n < 4; n++) zmem[n] = -1;
        run(3, 2, 1'b1);
        check_case1("restart");

        // Reset during the third write
        load_case1();
        w0 = wcnt;
        launch(3, 2);
        for (int j = 1; j <= 18; j++) begin
            tick();
            start = 1'b0;
        end
        chk("pre_rst_we", longint'(mem_z_we), 1);
        #1 rst_a = 1'b0;
        #1;
        chk("arst_we", longint'(mem_z_we), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_z_addr", longint'(mem_z_addr), 0);
        chk("arst_z_data", longint'(mem_z_data), 0);
        chk("arst_x_addr", longint'(mem_x_addr), 0);
        chk("arst_y_addr", longint'(mem_y_addr), 0);
        mon_on = 1'b0;
        repeat (3) tick();
        rst_a = 1'b1;
        repeat (4) tick();
        chk("rst_write_count", longint'(wcnt - w0), 3);
        for (int n = 0; n < 4; n++) zmem[n] = -1;
        run(3, 2, 1'b0);
        check_case1("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
